// File: rtl/fsm_lect_rtc.sv
// Read sequencer for the external parallel RTC on the muxed 8-bit AD bus.
// Sends the 0xF0 transfer command, then reads nine time/timer registers
// into a staging bank, and publishes all nine together when the sequence ends.
module fsm_lect_rtc #(
  parameter int T_PULSE = 9,
  parameter int T_GAP   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       do_it_lect,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] seg_tim,
  output logic [7:0] min_tim,
  output logic [7:0] hora_tim
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [4:0] LAST_STEP = 5'd19;

  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [4:0]      step, step_nxt;
  logic            cs_nxt, rd_nxt, wr_nxt, a_d_nxt, ad_oe_nxt, busy_nxt, done_nxt;
  logic [7:0]      ad_out_nxt;
  logic            cap, load, drive_p;
  logic [4:0]      ps;
  logic [3:0]      k_cur;
  logic [8:0][7:0] stage, snap;

  // Steps 0 and 1 are the command write; after that even steps are address
  // writes and odd steps are data reads.
  function automatic logic is_wr(input logic [4:0] s);
    return (s < 5'd2) || !s[0];
  endfunction

  // Byte driven onto the bus for a write-type step.
  function automatic logic [7:0] step_addr(input logic [4:0] s);
    logic [3:0] k;
    k = 4'((s - 5'd2) >> 1);
    if (s < 5'd2)        return 8'hF0;
    else if (k < 4'd6)   return 8'h21 + {4'd0, k};
    else                 return 8'h3B + {4'd0, k};
  endfunction

  // Register slot for the current read step (step 3 -> 0 ... step 19 -> 8).
  assign k_cur = 4'((step - 5'd2) >> 1);

  // State, timing counter and step index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      step  <= step_nxt;
    end
  end

  // Next state plus the next value of every registered bus/status output.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    step_nxt   = step;
    cs_nxt     = 1'b1;
    rd_nxt     = 1'b1;
    wr_nxt     = 1'b1;
    a_d_nxt    = 1'b1;
    ad_oe_nxt  = 1'b0;
    ad_out_nxt = ad_out;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    cap        = 1'b0;
    load       = 1'b0;
    drive_p    = 1'b0;
    ps         = step;
    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (do_it_lect) begin
          state_nxt = PULSE;
          cnt_nxt   = '0;
          step_nxt  = '0;
          busy_nxt  = 1'b1;
          drive_p   = 1'b1;
          ps        = '0;
        end
      end
      PULSE: begin
        if (cnt == 8'(T_PULSE - 1)) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          // keep driving one extra cycle after a write for hold time
          ad_oe_nxt = is_wr(step);
          cap       = !is_wr(step);
        end else begin
          cnt_nxt = cnt + 8'd1;
          drive_p = 1'b1;
        end
      end
      GAP: begin
        if (cnt == 8'(T_GAP - 1)) begin
          cnt_nxt = '0;
          if (step == LAST_STEP) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            load      = 1'b1;
          end else begin
            state_nxt = PULSE;
            step_nxt  = step + 5'd1;
            drive_p   = 1'b1;
            ps        = step + 5'd1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (drive_p) begin
      cs_nxt = 1'b0;
      if (is_wr(ps)) begin
        wr_nxt     = 1'b0;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = step_addr(ps);
        a_d_nxt    = ps[0];
      end else begin
        rd_nxt = 1'b0;
      end
    end
  end

  // Registered bus strobes and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs     <= 1'b1;
      rd     <= 1'b1;
      wr     <= 1'b1;
      a_d    <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      cs     <= cs_nxt;
      rd     <= rd_nxt;
      wr     <= wr_nxt;
      a_d    <= a_d_nxt;
      ad_oe  <= ad_oe_nxt;
      ad_out <= ad_out_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Staging bank captures each read; the snapshot updates only at completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
      snap  <= '0;
    end else begin
      if (cap)  stage[k_cur] <= ad_in;
      if (load) snap <= stage;
    end
  end

  assign seg      = snap[0];
  assign min      = snap[1];
  assign hora     = snap[2];
  assign dia      = snap[3];
  assign mes      = snap[4];
  assign anio     = snap[5];
  assign seg_tim  = snap[6];
  assign min_tim  = snap[7];
  assign hora_tim = snap[8];

endmodule

// File: tb/tb_fsm_lect_rtc.sv
// Bench: two sequencers (default timing and T_PULSE=3/T_GAP=2) each talking to
// an RTC model, checked every cycle against a cycle-position timing model.
module tb_fsm_lect_rtc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       do_it_lect = 1'b0;
  logic [7:0] ad_in [2];
  logic [7:0] ad_out[2];
  logic       ad_oe[2], a_d[2], cs[2], rd[2], wr[2], busy[2], done[2];
  logic [7:0] q[2][9];

  always #5 clk = ~clk;

  fsm_lect_rtc u0 (
    .clk(clk), .reset(reset), .do_it_lect(do_it_lect), .ad_in(ad_in[0]),
    .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .a_d(a_d[0]), .cs(cs[0]), .rd(rd[0]),
    .wr(wr[0]), .busy(busy[0]), .done(done[0]),
    .seg(q[0][0]), .min(q[0][1]), .hora(q[0][2]), .dia(q[0][3]), .mes(q[0][4]),
    .anio(q[0][5]), .seg_tim(q[0][6]), .min_tim(q[0][7]), .hora_tim(q[0][8]));

  fsm_lect_rtc #(.T_PULSE(3), .T_GAP(2)) u1 (
    .clk(clk), .reset(reset), .do_it_lect(do_it_lect), .ad_in(ad_in[1]),
    .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .a_d(a_d[1]), .cs(cs[1]), .rd(rd[1]),
    .wr(wr[1]), .busy(busy[1]), .done(done[1]),
    .seg(q[1][0]), .min(q[1][1]), .hora(q[1][2]), .dia(q[1][3]), .mes(q[1][4]),
    .anio(q[1][5]), .seg_tim(q[1][6]), .min_tim(q[1][7]), .hora_tim(q[1][8]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem[256];
  logic [7:0] lat[2];
  logic [7:0] lit[9];
  logic [7:0] reg_addr[9];

  // model state
  bit         act[2];
  int         t[2];
  logic [7:0] stg[2][9], snp[2][9];
  logic       e_cs[2], e_rd[2], e_wr[2], e_ad[2], e_oe[2], e_busy[2], e_done[2];
  logic [7:0] e_out[2];

  function automatic int tp(int d); return d ? 3 : 9; endfunction
  function automatic int tg(int d); return d ? 2 : 8; endfunction

  function automatic logic [7:0] addr_of(int s);
    int k;
    if (s < 2) return 8'hF0;
    k = (s - 2) / 2;
    return (k < 6) ? 8'(8'h21 + k) : 8'(8'h41 + k - 6);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a sequence is 20 slots of (pulse, gap); position t inside it
  // determines every bus signal.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        act[d] = 0; t[d] = 0;
        e_cs[d] = 1; e_rd[d] = 1; e_wr[d] = 1; e_ad[d] = 1; e_oe[d] = 0;
        e_busy[d] = 0; e_done[d] = 0; e_out[d] = 8'h00;
        for (int i = 0; i < 9; i++) begin stg[d][i] = 8'h00; snp[d][i] = 8'h00; end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int P, s, ph;
        bit pulse, wrt;
        P = tp(d) + tg(d);
        e_done[d] = 0;
        if (act[d]) begin
          s = t[d] / P; ph = t[d] % P;
          if (s >= 3 && s % 2 == 1 && ph == tp(d) - 1) stg[d][(s - 3) / 2] = ad_in[d];
          t[d]++;
          if (t[d] == 20 * P) begin
            act[d] = 0; e_done[d] = 1;
            for (int i = 0; i < 9; i++) snp[d][i] = stg[d][i];
          end
        end else if (do_it_lect) begin
          act[d] = 1; t[d] = 0;
        end
        if (act[d]) begin
          s = t[d] / P; ph = t[d] % P;
          pulse = (ph < tp(d));
          wrt = (s < 2) || (s % 2 == 0);
          e_cs[d] = !pulse;
          e_wr[d] = !(pulse && wrt);
          e_rd[d] = !(pulse && !wrt);
          e_ad[d] = !(pulse && s % 2 == 0);
          e_oe[d] = wrt && (ph <= tp(d));
          if (pulse && wrt) e_out[d] = addr_of(s);
          e_busy[d] = 1;
        end else begin
          e_cs[d] = 1; e_rd[d] = 1; e_wr[d] = 1; e_ad[d] = 1; e_oe[d] = 0; e_busy[d] = 0;
        end
      end
    end
  end

  // Per-cycle compare, then the RTC model answers on the bus.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [14:0] gv, ev;
      if (!reset) begin
        gv = {cs[d], rd[d], wr[d], a_d[d], ad_oe[d], busy[d], done[d], ad_out[d]};
        ev = {e_cs[d], e_rd[d], e_wr[d], e_ad[d], e_oe[d], e_busy[d], e_done[d], e_out[d]};
        checks++;
        if (gv !== ev) begin
          errors++;
          $display("FAIL bus dut%0d cyc %0d got cs,rd,wr,a_d,oe,busy,done,out=%b want %b",
                   d, cyc, gv, ev);
        end
        for (int i = 0; i < 9; i++) begin
          checks++;
          if (q[d][i] !== snp[d][i]) begin
            errors++;
            $display("FAIL data dut%0d reg%0d cyc %0d got %h want %h", d, i, cyc, q[d][i], snp[d][i]);
          end
        end
      end
      if (!cs[d] && !wr[d] && !a_d[d]) lat[d] = ad_out[d];
      ad_in[d] = !rd[d] ? mem[lat[d]] : 8'($urandom);
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy[0] && !busy[1]) begin ok = 1; break; end
      @(negedge clk);
    end
    check("idle_wait", ok, 1);
  endtask

  // One pulse on do_it_lect; measure cycles from acceptance to done for both.
  task automatic run_read(output int l0, output int l1);
    int c0;
    l0 = -1; l1 = -1;
    @(negedge clk);
    c0 = cyc;
    do_it_lect = 1'b1;
    @(negedge clk);
    do_it_lect = 1'b0;
    for (int i = 0; i < 400 && (l0 < 0 || l1 < 0); i++) begin
      if (done[0] && l0 < 0) l0 = cyc - c0;
      if (done[1] && l1 < 0) l1 = cyc - c0;
      @(negedge clk);
    end
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 9; i++) mem[reg_addr[i]] = 8'($urandom);
  endtask

  initial begin
    int l0, l1;
    lit = '{8'h59, 8'h34, 8'h12, 8'h28, 8'h02, 8'h16, 8'h10, 8'h20, 8'h03};
    reg_addr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) mem[reg_addr[i]] = lit[i];
    ad_in[0] = 8'h00; ad_in[1] = 8'h00; lat[0] = 8'h00; lat[1] = 8'h00;

    // reset state
    tick(3);
    check("rst_cs", cs[0], 1);
    check("rst_rd_wr", {rd[0], wr[0]}, 2'b11);
    check("rst_a_d", a_d[0], 1);
    check("rst_oe_busy_done", {ad_oe[0], busy[0], done[0]}, 3'b000);
    check("rst_ad_out", ad_out[0], 8'h00);
    reset = 1'b0;
    tick(2);

    // basic read with known register contents
    run_read(l0, l1);
    check("latency_default", l0, 341);
    check("latency_fast", l1, 101);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 9; i++) check($sformatf("basic_dut%0d_reg%0d", d, i), q[d][i], lit[i]);
    check("busy_after", {busy[0], busy[1]}, 2'b00);
    wait_idle();

    // snapshot consistency: RTC contents change mid-sequence
    tick(3);
    do_it_lect = 1'b1; tick(1); do_it_lect = 1'b0;
    tick(150);
    rand_regs();
    wait_idle();

    // start held high for 400 cycles: back-to-back sequences
    tick(2);
    do_it_lect = 1'b1;
    tick(400);
    do_it_lect = 1'b0;
    tick(1);
    wait_idle();

    // reset mid-operation
    tick(2);
    do_it_lect = 1'b1; tick(1); do_it_lect = 1'b0;
    tick(150);
    #1 reset = 1'b1;
    #1;
    check("midrst_strobes", {cs[0], rd[0], wr[0]}, 3'b111);
    check("midrst_oe", ad_oe[0], 0);
    check("midrst_seg", q[0][0], 8'h00);
    check("midrst_hora_tim", q[0][8], 8'h00);
    @(negedge clk);
    reset = 1'b0;
    tick(5);
    check("midrst_no_restart", {busy[0], busy[1]}, 2'b00);
    for (int i = 0; i < 9; i++) mem[reg_addr[i]] = lit[i];
    run_read(l0, l1);
    check("latency_after_rst", l0, 341);
    check("seg_after_rst", q[0][0], 8'h59);

    // randomized runs
    for (int n = 0; n < 6; n++) begin
      rand_regs();
      tick($urandom_range(0, 20));
      do_it_lect = 1'b1;
      tick($urandom_range(1, 30));
      do_it_lect = 1'b0;
      tick(1);
      if (($urandom & 1) == 1) begin tick($urandom_range(1, 80)); rand_regs(); end
      wait_idle();
    end
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_lect_rtc.md
Name: fsm_lect_rtc

Overview:
Read sequencer for the external parallel RTC on the multiplexed 8-bit address/data bus. On request it issues a transfer command to the RTC, then reads nine time/timer registers. It captures each byte into a staging bank and commits all nine at once, so consumers always see a consistent snapshot. It complements the RTC init/write path and generates its own bus cycles: a_d, cs, rd, wr plus the tristate enable for the AD bus.

Parameters:
T_PULSE, 9, clock cycles cs and rd/wr are held low per bus cycle (legal range 2..255).
T_GAP, 8, clock cycles all strobes are high between bus cycles (legal range 2..255).

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
do_it_lect  in  1  start request, sampled only in IDLE
ad_in  in  8  AD bus read value (from pad)
ad_out  out  8  AD bus drive value
ad_oe  out  1  AD bus output enable (1 = drive)
a_d  out  1  0 = address phase, 1 = data phase
cs  out  1  chip select, active-low
rd  out  1  read strobe, active-low
wr  out  1  write strobe, active-low
busy  out  1  sequence in progress
done  out  1  one-cycle pulse, snapshot committed
seg, min, hora, dia, mes, anio  out  8 each  committed RTC date/time bytes (BCD as read)
seg_tim, min_tim, hora_tim  out  8 each  committed timer bytes

Behaviour:
- Clock and reset: clk; reset is asynchronous, active-high.
- All outputs are registered.
- Reset values: cs=rd=wr=1, a_d=1, ad_oe=0, ad_out=0x00, busy=0, done=0, all data outputs 0x00, staging bank 0x00, state IDLE.
- States:
  - IDLE: waits for a start.
  - PULSE: strobes low for T_PULSE cycles.
  - GAP: strobes high for T_GAP cycles.
- Step index: 5-bit, 0..19.
- Start: do_it_lect=1 in IDLE. On the next cycle: busy=1, step=0, PULSE.
- do_it_lect is ignored while busy.
- Step list (addr/data):
  - Step 0: write address 0xF0 (transfer command).
  - Step 1: write data 0xF0.
  - Steps 2k+2 / 2k+3, k=0..8: write address A_k, then read data.
  - A_k = 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 anio, 0x41 seg_tim, 0x42 min_tim, 0x43 hora_tim.
- PULSE outputs:
  - Address step: cs=0, wr=0, rd=1, a_d=0, ad_oe=1, ad_out=address.
  - Write-data step: cs=0, wr=0, rd=1, a_d=1, ad_oe=1, ad_out=0xF0.
  - Read step: cs=0, rd=0, wr=1, a_d=1, ad_oe=0.
- GAP outputs: cs=rd=wr=1, a_d=1.
  - ad_oe stays 1 for the first GAP cycle after a write-type PULSE (hold time), then 0.
  - ad_out holds its last value.
- Sampling: ad_in is captured into staging[k] at the clock edge ending the last cycle of a read PULSE (rd still 0 in that cycle).
- Transitions:
  - PULSE→GAP when the pulse counter reaches T_PULSE-1.
  - GAP→PULSE with step+1 when the gap counter reaches T_GAP-1 and step<19.
  - GAP→IDLE when step==19.
- Completion: on the first IDLE cycle after step 19: done=1 for exactly one cycle, busy=0, all nine outputs loaded from staging in the same cycle.
- Data outputs are otherwise unchanged, including through a whole sequence.
- Latency: start accepted at edge E → done high at E + 20·(T_PULSE+T_GAP) + 1 cycles. Defaults give 341.
- Back-to-back: do_it_lect high during the done cycle is accepted; the next PULSE begins the following cycle.
- Reset mid-operation:
  - Strobes immediately go high and ad_oe=0.
  - Staging and outputs clear to 0x00; no done pulse.
  - After release, a new do_it_lect is required.
- Counters saturate never; widths are 8 bits for the timing counters and 5 bits for the step index.

Test Plan:
- Basic read: RTC model returns 0x59, 0x34, 0x12, 0x28, 0x02, 0x16, 0x10, 0x20, 0x03 for addresses 0x21..0x43; pulse do_it_lect → done after 341 cycles; outputs equal those values; busy=0.
- Bus protocol check, defaults:
  - Exactly 20 cs low pulses, each 9 cycles wide, separated by 8 cycles high.
  - 11 wr pulses and 9 rd pulses; a_d=0 only during the 10 address pulses.
  - ad_out matches the step list; ad_oe never 1 while rd=0.
- Snapshot consistency: change model values mid-sequence; outputs stay at old values until the done cycle, then all nine update together.
- Ignore while busy: hold do_it_lect high for 400 cycles → second sequence starts the cycle after done; no pulse is truncated; busy low only in the done cycle.
- Reset mid-op: assert reset at cycle 150 → same cycle cs=rd=wr=1, ad_oe=0; outputs 0x00; no done pulse; a fresh start then completes normally.
- Override T_PULSE=3, T_GAP=2 → done 101 cycles after acceptance; each cs pulse is 3 cycles wide.
